// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one combinational memory port between instruction fetch (IF,
// read-only) and the load/store unit (LSU, read/write). Each granted access
// drives mem_en for exactly one cycle, so the memory model sees exactly one
// read or write call per request.
//
// Sequence per access: IDLE (grant) -> ACCESS (mem_en=1) -> RESP (resp_valid=1).
// The LSU has priority. If IF has been waiting through STARVE_LIMIT
// consecutive LSU grants, the next grant goes to IF.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   if_req_valid/ready, if_addr     IF read request handshake
//   if_resp_valid, if_rdata         IF response pulse and held read data
//   lsu_req_valid/ready, lsu_wen,   LSU request handshake; wen=1 is a write
//   lsu_addr, lsu_wdata, lsu_wmask
//   lsu_resp_valid, lsu_rdata       LSU response pulse; rdata is 0 for writes
//   mem_en, mem_wen, mem_raddr,     memory port; all zero outside ACCESS
//   mem_waddr, mem_wdata, mem_wmask
//   mem_rdata                       combinational read data from the model
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W       = 64,
   parameter int DATA_W       = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_resp_valid,
   output logic [DATA_W-1:0] if_rdata,

   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic              lsu_wen,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [7:0]        lsu_wmask,
   output logic              lsu_resp_valid,
   output logic [DATA_W-1:0] lsu_rdata,

   output logic              mem_en,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [7:0]        mem_wmask,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t           state;
   logic             owner_lsu;   // 1: access in flight belongs to the LSU
   logic [CNT_W-1:0] starve_cnt;  // consecutive LSU grants while IF waited
   logic             grant_lsu;
   logic             grant_if;

   // Grant decision. Only made in IDLE. It is gated by rst_n so that no ready
   // is shown while reset is asserted.
   // NOTE: every signal driven here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      grant_lsu = 1'b0;
      grant_if  = 1'b0;
      if (rst_n && state == IDLE) begin
         if (lsu_req_valid && (!if_req_valid || starve_cnt < LIMIT))
            grant_lsu = 1'b1;
         else if (if_req_valid)
            grant_if = 1'b1;
      end
   end

   assign if_req_ready  = grant_if;
   assign lsu_req_ready = grant_lsu;

   // The request is latched straight into the mem_* registers at the grant
   // edge. Those registers are non-zero only for the single ACCESS cycle.
   // NOTE: state is updated with non-blocking assignments, so every branch
   // reads the values from before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         owner_lsu      <= 1'b0;
         starve_cnt     <= '0;
         mem_en         <= 1'b0;
         mem_wen        <= 1'b0;
         mem_raddr      <= '0;
         mem_waddr      <= '0;
         mem_wdata      <= '0;
         mem_wmask      <= '0;
         if_resp_valid  <= 1'b0;
         if_rdata       <= '0;
         lsu_resp_valid <= 1'b0;
         lsu_rdata      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_lsu) begin
                  state     <= ACCESS;
                  owner_lsu <= 1'b1;
                  mem_en    <= 1'b1;
                  mem_wen   <= lsu_wen;
                  mem_raddr <= lsu_addr;
                  mem_waddr <= lsu_addr;
                  mem_wdata <= lsu_wen ? lsu_wdata : '0;
                  mem_wmask <= lsu_wen ? lsu_wmask : 8'h00;
                  // The count only grows while IF is actually being passed over.
                  starve_cnt <= if_req_valid ? starve_cnt + CNT_W'(1) : '0;
               end else if (grant_if) begin
                  state      <= ACCESS;
                  owner_lsu  <= 1'b0;
                  mem_en     <= 1'b1;
                  mem_wen    <= 1'b0;
                  mem_raddr  <= if_addr;
                  mem_waddr  <= if_addr;
                  mem_wdata  <= '0;
                  mem_wmask  <= 8'h00;
                  starve_cnt <= '0;
               end
            end

            ACCESS: begin
               state     <= RESP;
               mem_en    <= 1'b0;
               mem_wen   <= 1'b0;
               mem_raddr <= '0;
               mem_waddr <= '0;
               mem_wdata <= '0;
               mem_wmask <= 8'h00;
               if (owner_lsu) begin
                  lsu_resp_valid <= 1'b1;
                  lsu_rdata      <= mem_wen ? '0 : mem_rdata;
               end else begin
                  if_resp_valid <= 1'b1;
                  if_rdata      <= mem_rdata;
               end
            end

            RESP: begin
               state          <= IDLE;
               if_resp_valid  <= 1'b0;
               lsu_resp_valid <= 1'b0;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. It contains a small byte-masked memory
// model that reads combinationally and writes at the clock edge, and counts
// read and write calls. Inputs are driven on the falling edge. Outputs are
// sampled 1 ns after that edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req_valid, if_req_ready, if_resp_valid;
   logic [63:0] if_addr, if_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
   logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [7:0]  lsu_wmask;
   logic        mem_en, mem_wen;
   logic [63:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
   logic [7:0]  mem_wmask;

   int n_checks = 0;
   int n_errors = 0;
   int n_reads  = 0;
   int n_writes = 0;

   logic [63:0] mem [0:8191];

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
      .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
      .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
      .mem_en(mem_en), .mem_wen(mem_wen), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
   );

   // Memory model: combinational read, byte-masked write at the edge.
   always_comb mem_rdata = (mem_en && !mem_wen) ? mem[mem_raddr[15:3]] : 64'h0;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_wen) begin
            for (int b = 0; b < 8; b++)
               if (mem_wmask[b]) mem[mem_waddr[15:3]][8*b +: 8] = mem_wdata[8*b +: 8];
            n_writes++;
         end else begin
            n_reads++;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rd0, wr0, grants, both;
      logic [9:0] order;

      for (int i = 0; i < 8192; i++) mem[i] = 64'h0;
      mem[0]     = 64'h0000_0000_0000_0013;  // 0x8000_0000
      mem[13'h200] = 64'h1111_1111_1111_1111;  // 0x8000_1000

      rst_n = 1'b0;
      if_req_valid = 1'b0; if_addr = '0;
      lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;

      // ---- reset state; a valid request during reset must not see ready
      repeat (2) @(negedge clk);
      if_req_valid = 1'b1;
      #1;
      check("rst_mem_en", mem_en, 0);
      check("rst_if_ready", if_req_ready, 0);
      check("rst_lsu_ready", lsu_req_ready, 0);
      check("rst_if_resp", if_resp_valid, 0);
      check("rst_lsu_resp", lsu_resp_valid, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_lsu_rdata", lsu_rdata, 0);
      @(negedge clk);
      if_req_valid = 1'b0;
      rst_n = 1'b1;

      // ---- reset in the middle of an IF read
      @(negedge clk);
      if_req_valid = 1'b1; if_addr = 64'h100;
      #1 check("mid_if_ready", if_req_ready, 1);
      @(negedge clk);
      if_req_valid = 1'b0;
      #1 check("mid_access_en", mem_en, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_en", mem_en, 0);
      check("mid_rst_raddr", mem_raddr, 0);
      @(negedge clk);
      #1 check("mid_rst_no_resp", if_resp_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("mid_rel_resp", if_resp_valid, 0);
      @(negedge clk);
      #1;
      check("mid_idle_en", mem_en, 0);
      check("mid_idle_resp", if_resp_valid, 0);

      // ---- single IF read
      rd0 = n_reads;
      @(negedge clk);
      if_req_valid = 1'b1; if_addr = 64'h8000_0000;
      #1;
      check("if_ready_c0", if_req_ready, 1);
      check("if_lsu_ready_c0", lsu_req_ready, 0);
      check("if_en_c0", mem_en, 0);
      @(negedge clk);
      #1;
      check("if_en_c1", mem_en, 1);
      check("if_raddr_c1", mem_raddr, 64'h8000_0000);
      check("if_wen_c1", mem_wen, 0);
      check("if_wdata_c1", mem_wdata, 0);
      check("if_busy_ready_c1", if_req_ready, 0);
      @(negedge clk);
      if_req_valid = 1'b0;
      #1;
      check("if_resp_c2", if_resp_valid, 1);
      check("if_rdata_c2", if_rdata, 64'h13);
      check("if_en_c2", mem_en, 0);
      @(negedge clk);
      #1;
      check("if_resp_c3", if_resp_valid, 0);
      check("if_rdata_hold", if_rdata, 64'h13);
      check("if_read_calls", n_reads - rd0, 1);

      // ---- LSU write then read-after-write held back-to-back
      wr0 = n_writes;
      @(negedge clk);
      lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h8000_1000;
      lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F;
      #1 check("wr_ready_c0", lsu_req_ready, 1);
      @(negedge clk);
      lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
      #1;
      check("wr_en_c1", mem_en, 1);
      check("wr_wen_c1", mem_wen, 1);
      check("wr_waddr_c1", mem_waddr, 64'h8000_1000);
      check("wr_wdata_c1", mem_wdata, 64'hDEAD_BEEF);
      check("wr_wmask_c1", mem_wmask, 64'h0F);
      check("wr_busy_ready_c1", lsu_req_ready, 0);
      @(negedge clk);
      #1;
      check("wr_resp_c2", lsu_resp_valid, 1);
      check("wr_rdata_c2", lsu_rdata, 0);
      check("wr_write_calls", n_writes - wr0, 1);
      check("wr_busy_ready_c2", lsu_req_ready, 0);
      @(negedge clk);
      #1;
      check("raw_ready_c3", lsu_req_ready, 1);
      check("raw_resp_c3", lsu_resp_valid, 0);
      @(negedge clk);
      lsu_req_valid = 1'b0;
      #1;
      check("raw_en_c4", mem_en, 1);
      check("raw_wen_c4", mem_wen, 0);
      check("raw_wmask_c4", mem_wmask, 0);
      check("raw_raddr_c4", mem_raddr, 64'h8000_1000);
      @(negedge clk);
      #1;
      check("raw_resp_c5", lsu_resp_valid, 1);
      check("raw_rdata_c5", lsu_rdata, 64'h1111_1111_DEAD_BEEF);

      // ---- upper-half write: lsu_rdata returns to 0 for a write
      @(negedge clk);
      lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_wdata = 64'h0123_4567_89AB_CDEF; lsu_wmask = 8'hF0;
      #1 check("wr2_ready", lsu_req_ready, 1);
      @(negedge clk);
      lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
      @(negedge clk);
      #1;
      check("wr2_resp", lsu_resp_valid, 1);
      check("wr2_rdata_zero", lsu_rdata, 0);

      // ---- simultaneous requests: LSU first, IF at the next IDLE
      @(negedge clk);
      lsu_req_valid = 1'b1; if_req_valid = 1'b1; if_addr = 64'h8000_0000;
      #1;
      check("sim_lsu_ready", lsu_req_ready, 1);
      check("sim_if_ready0", if_req_ready, 0);
      @(negedge clk);
      lsu_req_valid = 1'b0;
      #1 check("sim_lsu_raddr", mem_raddr, 64'h8000_1000);
      @(negedge clk);
      #1;
      check("sim_lsu_resp", lsu_resp_valid, 1);
      check("sim_if_resp_early", if_resp_valid, 0);
      @(negedge clk);
      #1 check("sim_if_ready3", if_req_ready, 1);
      @(negedge clk);
      if_req_valid = 1'b0;
      #1 check("sim_if_raddr", mem_raddr, 64'h8000_0000);
      @(negedge clk);
      #1;
      check("sim_if_resp", if_resp_valid, 1);
      check("sim_lsu_resp_off", lsu_resp_valid, 0);

      // ---- starvation guard: both valid continuously
      rd0 = n_reads;
      grants = 0; both = 0; order = '0;
      @(negedge clk);
      lsu_req_valid = 1'b1; if_req_valid = 1'b1;
      for (int cyc = 0; cyc < 60 && grants < 10; cyc++) begin
         if (cyc != 0) @(negedge clk);
         #1;
         if (lsu_req_ready && if_req_ready) both++;
         if (lsu_req_ready) begin
            order = {order[8:0], 1'b1};
            grants++;
         end else if (if_req_ready) begin
            order = {order[8:0], 1'b0};
            grants++;
         end
      end
      @(negedge clk);
      lsu_req_valid = 1'b0; if_req_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("starve_grants", grants, 10);
      check("starve_order", order, 10'b11110_11110);
      check("starve_both_ready", both, 0);
      check("starve_mem_calls", n_reads - rd0, 10);
      check("starve_lsu_rdata", lsu_rdata, 64'h0123_4567_DEAD_BEEF);
      check("starve_idle_en", mem_en, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
